octave_downsampler: RTL

- Consumes the next-octave stream (pixel, valid, blanking) from an octave stage at full resolution.
- Produces a 2:1 horizontally and 2:1 vertically reduced stream in the same din/validin/blanking_in format, feeding the next octave's input.
- Operates in one of two modes: pure decimation, or 2x2 box averaging.
- Line and frame geometry is tracked by free-running slot/row counters.

---
 rtl/octave_downsampler.sv | 120 ++++++++++++
 1 files changed

// File: rtl/octave_downsampler.sv
// One-octave reduction stage: 2:1 horizontal and vertical, either decimating
// (keep even row/even column) or rounded 2x2 box averaging through a half-line buffer.
module octave_downsampler #(
    parameter int in_width  = 420,
    parameter int in_height = 240,
    parameter bit average   = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       validin,
    input  logic       blanking_in,
    output logic [7:0] dout,
    output logic       validout,
    output logic       blanking_out,
    output logic       frame_done
);
    localparam int CW    = $clog2(in_width);
    localparam int RW    = $clog2(in_height);
    localparam int DEPTH = in_width / 2;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          last_col, last_row;
    logic [7:0]    dout_q;
    logic          vld_q, blk_q, fd_q;

    assign last_col     = (col_q == CW'(in_width - 1));
    assign last_row     = (row_q == RW'(in_height - 1));
    assign dout         = dout_q;
    assign validout     = vld_q;
    assign blanking_out = blk_q;
    assign frame_done   = fd_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (validin) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
            fd_q  <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            fd_q  <= validin && last_col && last_row;
        end
    end

    if (average) begin : g_avg
        logic [7:0]    hold_q;
        logic          hold_blk_q;
        // {blanking flag, 9-bit sum of the horizontal pair from the even row}
        logic [9:0]    lb_q [DEPTH];
        logic [CW-2:0] idx;
        logic [9:0]    sum10, rnd;

        assign idx = col_q[CW-1:1];

        always_comb begin
            sum10 = {1'b0, lb_q[idx][8:0]} + {2'b00, hold_q} + {2'b00, din};
            rnd   = sum10 + 10'd2;
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                hold_q     <= '0;
                hold_blk_q <= 1'b0;
                dout_q     <= '0;
                vld_q      <= 1'b0;
                blk_q      <= 1'b0;
            end else begin
                vld_q <= 1'b0;
                blk_q <= 1'b0;
                if (validin) begin
                    if (!col_q[0]) begin
                        hold_q     <= din;
                        hold_blk_q <= blanking_in;
                    end else if (row_q[0]) begin
                        dout_q <= rnd[9:2];
                        blk_q  <= lb_q[idx][9] | hold_blk_q | blanking_in;
                        vld_q  <= 1'b1;
                    end
                end
            end
        end

        // Even rows write, odd rows read the same entry one line later.
        always_ff @(posedge clock) begin
            if (validin && col_q[0] && !row_q[0])
                lb_q[idx] <= {hold_blk_q | blanking_in, {1'b0, hold_q} + {1'b0, din}};
        end
    end else begin : g_dec
        always_ff @(posedge clock) begin
            if (reset) begin
                dout_q <= '0;
                vld_q  <= 1'b0;
                blk_q  <= 1'b0;
            end else begin
                vld_q <= 1'b0;
                blk_q <= 1'b0;
                if (validin && !col_q[0] && !row_q[0]) begin
                    dout_q <= din;
                    blk_q  <= blanking_in;
                    vld_q  <= 1'b1;
                end
            end
        end
    end
endmodule
